// File: rtl/fifo_rd_ctrl.sv
// Read-side FIFO controller: issues pops and absorbs the one-cycle read latency in a 2-entry skid buffer.
// Optional macro RD_BURST_EN gates the start of reading on the almost-empty flag (or flush).
module fifo_rd_ctrl #(
  parameter int DATA_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fifo_empty,
  input  logic              fifo_almost_empty,
  input  logic [DATA_W-1:0] fifo_data_out,
  input  logic              flush,
  input  logic              ready_in,
  output logic              fifo_rd,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic [1:0]        state,
  output logic [7:0]        xfer_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    STALL = 2'b10
  } state_e;

  state_e            state_q;
  logic [1:0]        occ_q, occ_d;
  logic              inflight_q;
  logic [DATA_W-1:0] buf0_q, buf1_q, buf0_d, buf1_d;
  logic [7:0]        xfer_cnt_q;
  logic              pop;
  logic              start;
  logic [2:0]        committed;
  logic [1:0]        slot;

`ifdef RD_BURST_EN
  assign start = !fifo_empty && (!fifo_almost_empty || flush);
`else
  logic unused_burst;
  assign unused_burst = fifo_almost_empty ^ flush;
  assign start        = !fifo_empty;
`endif

  assign valid_out = (occ_q != 2'd0);
  assign pop       = valid_out && ready_in;

  // Entries that will be held after this edge: buffered plus in flight, minus the one leaving.
  assign committed = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign occ_d     = committed[1:0];
  assign fifo_rd   = (state_q == FETCH) && !fifo_empty && (committed < 3'd2);

  assign slot = occ_q - {1'b0, pop};

  always_comb begin
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    if (pop) begin
      buf0_d = buf1_q;
    end
    if (inflight_q) begin
      if (slot == 2'd0) begin
        buf0_d = fifo_data_out;
      end else begin
        buf1_d = fifo_data_out;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      buf0_q     <= '0;
      buf1_q     <= '0;
      xfer_cnt_q <= 8'd0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= fifo_rd;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      if (pop) begin
        xfer_cnt_q <= xfer_cnt_q + 8'd1;
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= FETCH;
          end
        end
        FETCH: begin
          if (fifo_empty) begin
            state_q <= IDLE;
          end else if ((occ_d == 2'd2) && !ready_in) begin
            state_q <= STALL;
          end
        end
        STALL: begin
          if (ready_in) begin
            state_q <= fifo_empty ? IDLE : FETCH;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign state    = state_q;
  assign data_out = buf0_q;
  assign xfer_cnt = xfer_cnt_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: array-backed FIFO model, in-order stream reference and directed plus random stimulus.
module tb_fifo_rd_ctrl;
  localparam int DATA_W = 6;
  localparam int DEPTH  = 2048;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              fifo_empty;
  logic              fifo_almost_empty = 1'b0;
  logic [DATA_W-1:0] fifo_data_out = '0;
  logic              flush = 1'b0;
  logic              ready_in = 1'b0;
  logic              fifo_rd;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic [1:0]        state;
  logic [7:0]        xfer_cnt;

  fifo_rd_ctrl #(.DATA_W(DATA_W)) dut (
    .clk               (clk),
    .reset             (reset),
    .fifo_empty        (fifo_empty),
    .fifo_almost_empty (fifo_almost_empty),
    .fifo_data_out     (fifo_data_out),
    .flush             (flush),
    .ready_in          (ready_in),
    .fifo_rd           (fifo_rd),
    .data_out          (data_out),
    .valid_out         (valid_out),
    .state             (state),
    .xfer_cnt          (xfer_cnt)
  );

  always #5 clk = ~clk;

  // FIFO model: words live in mem[rd_ptr .. wr_ptr-1], read data appears one cycle after fifo_rd.
  logic [DATA_W-1:0] mem [0:DEPTH-1];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (fifo_rd) begin
      fifo_data_out <= mem[rd_ptr];
      rd_ptr        <= rd_ptr + 1;
    end
  end

  // Reference: delivered words must be the pushed stream in order; count of deliveries mod 256.
  int exp_idx = 0;
  int model_cnt = 0;
  int errors = 0;
  int checks = 0;
  logic              prev_hold = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;
  int cyc_no, rd_cnt, vld_cnt, first_rd, last_rd, first_vld, last_vld;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [DATA_W-1:0] v);
    mem[wr_ptr] = v;
    wr_ptr++;
  endtask

  task automatic clear_stats();
    cyc_no = 0; rd_cnt = 0; vld_cnt = 0;
    first_rd = -1; last_rd = -1; first_vld = -1; last_vld = -1;
  endtask

  task automatic sample();
    #1;
    check("rd_while_empty", {31'b0, fifo_rd & fifo_empty}, 32'd0);
    check("xfer_cnt", {24'b0, xfer_cnt}, model_cnt % 256);
    if (prev_hold) begin
      check("hold_valid", {31'b0, valid_out}, 32'd1);
      check("hold_data", {26'b0, data_out}, {26'b0, prev_data});
    end
    if (valid_out && ready_in) begin
      if (exp_idx < DEPTH) check("data", {26'b0, data_out}, {26'b0, mem[exp_idx]});
      else check("data_overrun", exp_idx, DEPTH - 1);
      exp_idx++;
      model_cnt++;
    end
    prev_hold = valid_out && !ready_in;
    prev_data = data_out;
    if (fifo_rd) begin
      rd_cnt++;
      if (first_rd < 0) first_rd = cyc_no;
      last_rd = cyc_no;
    end
    if (valid_out) begin
      vld_cnt++;
      if (first_vld < 0) first_vld = cyc_no;
      last_vld = cyc_no;
    end
    cyc_no++;
  endtask

  task automatic cyc(input logic rdy);
    @(negedge clk);
    ready_in = rdy;
    sample();
  endtask

  // Asynchronous assertion away from any edge; outputs must clear at once.
  task automatic do_reset();
    reset = 1'b0;
    #1;
    check("rst_fifo_rd", {31'b0, fifo_rd}, 32'd0);
    check("rst_valid", {31'b0, valid_out}, 32'd0);
    check("rst_state", {30'b0, state}, 32'd0);
    check("rst_xfer", {24'b0, xfer_cnt}, 32'd0);
    check("rst_data", {26'b0, data_out}, 32'd0);
    exp_idx   = rd_ptr;
    model_cnt = 0;
    prev_hold = 1'b0;
  endtask

  task automatic release_rst();
    clear_stats();
    @(negedge clk);
    reset    = 1'b1;
    ready_in = 1'b1;
    sample();
  endtask

  task automatic drain(input int max_cyc);
    for (int i = 0; i < max_cyc && exp_idx != wr_ptr; i++) cyc(1'b1);
    check("drain_all", exp_idx, wr_ptr);
    for (int i = 0; i < 3; i++) cyc(1'b1);
    check("drain_idle", {30'b0, state}, 32'd0);
    check("drain_valid", {31'b0, valid_out}, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with three words waiting, then release and measure latency.
    push(6'h01); push(6'h02); push(6'h03);
    clear_stats();
    for (int i = 0; i < 3; i++) cyc(1'b1);
    do_reset();
    release_rst();
    for (int i = 0; i < 8; i++) cyc(1'b1);
    check("t1_first_rd", first_rd, 32'd1);
    check("t1_first_vld", first_vld, 32'd3);
    check("t1_delivered", exp_idx, 32'd3);
    check("t1_xfer", {24'b0, xfer_cnt}, 32'd3);
    drain(10);

    // Eight preloaded words streamed with ready held high.
    do_reset();
    for (int i = 0; i < 8; i++) push(DATA_W'($urandom));
    release_rst();
    drain(30);
    check("t2_rd_cnt", rd_cnt, 32'd8);
    check("t2_rd_span", last_rd - first_rd, 32'd7);
    check("t2_vld_cnt", vld_cnt, 32'd8);
    check("t2_vld_span", last_vld - first_vld, 32'd7);
    check("t2_xfer", {24'b0, xfer_cnt}, 32'd8);

    // Backpressure for five cycles mid-stream.
    for (int i = 0; i < 20; i++) push(DATA_W'($urandom));
    clear_stats();
    for (int i = 0; i < 6; i++) cyc(1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b0);
    check("t3_state", {30'b0, state}, 32'd2);
    check("t3_occ", {30'b0, dut.occ_q}, 32'd2);
    check("t3_fifo_rd", {31'b0, fifo_rd}, 32'd0);
    check("t3_valid", {31'b0, valid_out}, 32'd1);
    drain(60);

    // Random ready pattern with words trickling in.
    for (int i = 0; i < 30; i++) push(DATA_W'($urandom));
    for (int i = 0; i < 120; i++) begin
      cyc(1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) push(DATA_W'($urandom));
    end
    drain(150);

    // Reset while a word is in flight: that word and buffered ones are dropped.
    for (int i = 0; i < 30; i++) push(DATA_W'($urandom));
    for (int i = 0; i < 10; i++) cyc(1'b1);
    check("t5_pre_inflight", {31'b0, dut.inflight_q}, 32'd1);
    do_reset();
    release_rst();
    drain(80);

    // Counter wrap after 257 transfers.
    do_reset();
    for (int i = 0; i < 257; i++) push(DATA_W'($urandom));
    release_rst();
    drain(400);
    check("t6_wrap", {24'b0, xfer_cnt}, 32'd1);
    check("t6_total", model_cnt, 32'd257);

`ifdef RD_BURST_EN
    // Below threshold nothing is read until flush.
    do_reset();
    fifo_almost_empty = 1'b1;
    push(DATA_W'($urandom)); push(DATA_W'($urandom));
    release_rst();
    for (int i = 0; i < 5; i++) cyc(1'b1);
    check("t7_no_rd", rd_cnt, 32'd0);
    check("t7_idle", {30'b0, state}, 32'd0);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    drain(20);
    check("t7_rd_cnt", rd_cnt, 32'd2);
    check("t7_xfer", {24'b0, xfer_cnt}, 32'd2);
    fifo_almost_empty = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_rd_ctrl.md
# fifo_rd_ctrl

Read-side controller for the FIFO, downstream of the FIFO control/flag logic. It watches the FIFO `empty`/`almost_empty` flags, issues `fifo_rd` pulses to pop words, and absorbs the one-cycle read latency of the FIFO memory in a 2-entry skid buffer. It presents the words to the next stage over a valid/ready handshake with full throughput and no loss or duplication under backpressure.

## Interface
- `DATA_W`, 6: width of a FIFO word.
- `clk`  input  1  clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-low reset; `reset==0` clears all state immediately.
- `fifo_empty`  input  1  FIFO empty flag (combinational from FIFO occupancy).
- `fifo_almost_empty`  input  1  FIFO almost-empty flag; used only with `RD_BURST_EN`.
- `fifo_data_out`  input  DATA_W  FIFO read data; valid the cycle after `fifo_rd`.
- `flush`  input  1  forces reading to start regardless of the low-water rule; used only with `RD_BURST_EN`.
- `ready_in`  input  1  downstream ready.
- `fifo_rd`  output  1  pop request to the FIFO, one word per high cycle.
- `data_out`  output  DATA_W  head word of the skid buffer.
- `valid_out`  output  1  `data_out` is valid.
- `state`  output  2  FSM state: 00 IDLE, 01 FETCH, 10 STALL.
- `xfer_cnt`  output  8  count of accepted downstream transfers.

## Operation
- Skid buffer: 2 entries, `occ` is 0..2. `inflight` is 0..1 and equals `fifo_rd` registered from the previous cycle.
- `pop` = `valid_out && ready_in`. `valid_out` = (`occ != 0`). `data_out` is the oldest entry.
- Capture: when `inflight==1`, `fifo_data_out` is written into the buffer at that clock edge. A capture and a pop in the same cycle are both applied, and order is preserved.
- Issue rule: `fifo_rd` = (`state==FETCH`) && `!fifo_empty` && (`occ + inflight - pop < 2`). This is combinational on registered state plus inputs.
- `fifo_rd` must never be high while `fifo_empty==1` or `reset==0`.
- FSM:
  - IDLE → FETCH when the start condition holds. The start condition is `!fifo_empty`; with `RD_BURST_EN`, see Configuration.
  - FETCH → IDLE when `fifo_empty==1`.
  - FETCH → STALL when `occ==2` && `!ready_in` (evaluated on next-state `occ`).
  - STALL → FETCH when `ready_in==1`.
  - STALL → IDLE when `ready_in==1` && `fifo_empty==1`.
- Words already buffered or in flight keep draining in every state, including IDLE.
- `xfer_cnt` increments by 1 on each `pop`. It wraps from 255 to 0.
- Reset values: `fifo_rd`=0, `valid_out`=0, `data_out`=0, `state`=IDLE, `xfer_cnt`=0. `occ` and `inflight` are cleared, and any in-flight word is discarded.
- Reset asserted mid-transfer: outputs go to reset values without waiting for a clock edge. After release, the block restarts from IDLE.

## Timing
- Read latency: `fifo_rd` high in cycle t → `fifo_data_out` valid in cycle t+1 → captured at the end of t+1 → `valid_out` high in t+2. Minimum latency is 2 cycles.
- Streaming with `ready_in` held at 1 sustains one word per cycle after the first 2-cycle fill.
- Backpressure: when `ready_in` drops, at most 2 words are held (1 buffered + 1 in flight, or 2 buffered). No new `fifo_rd` is issued until a pop frees space. `data_out` is stable while `valid_out && !ready_in`.
- FIFO with a single word: `fifo_rd` is high for exactly 1 cycle. `fifo_empty` rises the next cycle, and the FSM returns to IDLE.

## Configuration
- Macro `RD_BURST_EN`.
- Defined:
  - IDLE → FETCH only when `!fifo_empty && (!fifo_almost_empty || flush)`.
  - Reads therefore start in bursts once the FIFO rises above its empty threshold.
  - `flush` drains a partially filled FIFO.
  - Once in FETCH, reading continues until `fifo_empty`.
- Not defined: `fifo_almost_empty` and `flush` are ignored, and reading starts as soon as `!fifo_empty`.

## Test plan
- Reset with `reset=0` while the FIFO holds 3 words → `fifo_rd`=0, `valid_out`=0, `state`=00, `xfer_cnt`=0 immediately. After release with `ready_in=1`: first `fifo_rd` in cycle 1, first `valid_out` 2 cycles later, and words 0x01, 0x02, 0x03 appear in order.
- FIFO preloaded with 8 words, `ready_in=1` throughout → 8 consecutive `fifo_rd` cycles, 8 consecutive valid words, `xfer_cnt`=8, and `fifo_rd` never high with `fifo_empty=1`.
- Backpressure: streaming, then `ready_in=0` for 5 cycles → `state`=10, `occ`=2, `fifo_rd`=0, and `data_out` held constant. On `ready_in=1`, the sequence resumes with no word lost or duplicated.
- Reset asserted mid-stream while `inflight=1` → the in-flight word is dropped and `valid_out` goes to 0 asynchronously. After release, the next word comes from the FIFO head.
- `xfer_cnt` wrap: 257 accepted transfers → `xfer_cnt`=1.
- `RD_BURST_EN` defined with 2 words in the FIFO and `fifo_almost_empty=1` → no `fifo_rd`. Asserting `flush` for 1 cycle → both words are read and delivered, then `state`=IDLE.
